// File: rtl/vga_sprite_compositor.sv
// Multi-slot sprite blitter into a framebuffer RAM with colour-key transparency,
// screen-edge clipping and periodic whole-frame refresh to the VGA adapter.
module vga_sprite_compositor #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int SPRITE_W    = 30,
    parameter int SPRITE_H    = 20,
    parameter int NUM_SLOTS   = 5,
    parameter int SEL_W       = 2,
    parameter int COLOUR_W    = 3,
    parameter int REFRESH_DIV = 1250000,
    parameter int KEY_EN      = 1,
    parameter int KEY_COLOUR  = 0
) (
    input  logic                                  clk,
    input  logic                                  iResetn,
    input  logic [NUM_SLOTS-1:0]                  iSlotReq,
    input  logic [NUM_SLOTS*SEL_W-1:0]            iSlotSel,
    input  logic [NUM_SLOTS*X_W-1:0]              iSlotX,
    input  logic [NUM_SLOTS*Y_W-1:0]              iSlotY,
    output logic [SEL_W-1:0]                      oSprSel,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  oSprAddr,
    input  logic [COLOUR_W-1:0]                   iSprColour,
    output logic [$clog2(SCREEN_W*SCREEN_H)-1:0]  oFbAddr,
    output logic                                  oFbWren,
    output logic [COLOUR_W-1:0]                   oFbData,
    input  logic [COLOUR_W-1:0]                   iFbQ,
    output logic [X_W-1:0]                        oX,
    output logic [Y_W-1:0]                        oY,
    output logic [COLOUR_W-1:0]                   oColour,
    output logic                                  oPlot,
    output logic                                  oBusy,
    output logic                                  oFrameDone,
    output logic                                  oFrameMiss
);
    localparam int SPR_N  = SPRITE_W * SPRITE_H;
    localparam int FB_N   = SCREEN_W * SCREEN_H;
    localparam int SPR_AW = $clog2(SPR_N);
    localparam int FB_AW  = $clog2(FB_N);
    localparam int TMR_W  = $clog2(REFRESH_DIV);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [X_W-1:0]   SX_LAST = X_W'(SPRITE_W - 1);
    localparam logic [X_W-1:0]   RX_LAST = X_W'(SCREEN_W - 1);
    localparam logic [X_W:0]     SCR_W_C = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]     SCR_H_C = (Y_W+1)'(SCREEN_H);
    localparam logic [COLOUR_W-1:0] KEY_C = COLOUR_W'(KEY_COLOUR);

    typedef enum logic [1:0] {IDLE, BLIT, REFRESH, DRAIN} state_t;
    state_t state, stateNext;

    logic [NUM_SLOTS-1:0] pend;
    logic [SEL_W-1:0]     slotSel [NUM_SLOTS];
    logic [X_W-1:0]       slotX   [NUM_SLOTS];
    logic [Y_W-1:0]       slotY   [NUM_SLOTS];
    logic                 anyPend;
    logic [SLOT_W-1:0]    pickSlot;
    logic                 startBlit, startRef;

    logic [TMR_W-1:0]     tmr;
    logic                 tick, refPend;

    logic [X_W-1:0]       actX, sx, rx, plotX;
    logic [Y_W-1:0]       actY, sy, ry, plotY;
    logic [FB_AW-1:0]     refAddr, blitAddr;
    logic [X_W:0]         px;
    logic [Y_W:0]         py;
    logic                 pipeBlit, pipeRef, sprLast, fbLast, keyed, clipped;

    assign sprLast = (oSprAddr == SPR_AW'(SPR_N - 1));
    assign fbLast  = (refAddr == FB_AW'(FB_N - 1));
    assign tick    = (tmr == TMR_W'(REFRESH_DIV - 1));

    // Descending scan so the lowest pending index is the one left standing
    always_comb begin
        anyPend  = 1'b0;
        pickSlot = '0;
        for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
            if (pend[i-1]) begin
                anyPend  = 1'b1;
                pickSlot = SLOT_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iResetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        startBlit = 1'b0;
        startRef  = 1'b0;
        case (state)
            IDLE: begin
                if (refPend) begin
                    stateNext = REFRESH;
                    startRef  = 1'b1;
                end else if (anyPend) begin
                    stateNext = BLIT;
                    startBlit = 1'b1;
                end
            end
            BLIT:    if (sprLast) stateNext = DRAIN;
            REFRESH: if (fbLast)  stateNext = DRAIN;
            DRAIN:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A same-cycle request lands after the clear, so it is never lost
    always_ff @(posedge clk) begin
        if (iResetn) begin
            pend <= '0;
        end else begin
            if (startBlit) pend[pickSlot] <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++)
                if (iSlotReq[i]) pend[i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (iSlotReq[i]) begin
                slotSel[i] <= iSlotSel[i*SEL_W +: SEL_W];
                slotX[i]   <= iSlotX[i*X_W +: X_W];
                slotY[i]   <= iSlotY[i*Y_W +: Y_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iResetn) begin
            tmr        <= '0;
            refPend    <= 1'b0;
            oFrameMiss <= 1'b0;
        end else begin
            tmr        <= tick ? '0 : tmr + TMR_W'(1);
            oFrameMiss <= tick && refPend && !startRef;
            if (tick)          refPend <= 1'b1;
            else if (startRef) refPend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (iResetn) begin
            oSprSel  <= '0;
            oSprAddr <= '0;
            sx       <= '0;
            sy       <= '0;
            actX     <= '0;
            actY     <= '0;
            pipeBlit <= 1'b0;
            px       <= '0;
            py       <= '0;
            refAddr  <= '0;
            rx       <= '0;
            ry       <= '0;
            pipeRef  <= 1'b0;
            plotX    <= '0;
            plotY    <= '0;
        end else begin
            pipeBlit <= (state == BLIT);
            px       <= {1'b0, actX} + {1'b0, sx};
            py       <= {1'b0, actY} + {1'b0, sy};
            pipeRef  <= (state == REFRESH);
            plotX    <= rx;
            plotY    <= ry;
            if (startBlit) begin
                oSprAddr <= '0;
                sx       <= '0;
                sy       <= '0;
                actX     <= slotX[pickSlot];
                actY     <= slotY[pickSlot];
                oSprSel  <= slotSel[pickSlot];
            end else if (state == BLIT && !sprLast) begin
                oSprAddr <= oSprAddr + SPR_AW'(1);
                if (sx == SX_LAST) begin
                    sx <= '0;
                    sy <= sy + Y_W'(1);
                end else begin
                    sx <= sx + X_W'(1);
                end
            end
            if (startRef) begin
                refAddr <= '0;
                rx      <= '0;
                ry      <= '0;
            end else if (state == REFRESH && !fbLast) begin
                refAddr <= refAddr + FB_AW'(1);
                if (rx == RX_LAST) begin
                    rx <= '0;
                    ry <= ry + Y_W'(1);
                end else begin
                    rx <= rx + X_W'(1);
                end
            end
        end
    end

    assign keyed    = (KEY_EN != 0) && (iSprColour == KEY_C);
    assign clipped  = (px >= SCR_W_C) || (py >= SCR_H_C);
    assign blitAddr = FB_AW'(py) * FB_AW'(SCREEN_W) + FB_AW'(px);

    assign oFbWren    = pipeBlit && !keyed && !clipped;
    assign oFbData    = pipeBlit ? iSprColour : '0;
    assign oFbAddr    = (state == REFRESH) ? refAddr : (pipeBlit ? blitAddr : '0);
    assign oPlot      = pipeRef;
    assign oX         = pipeRef ? plotX : '0;
    assign oY         = pipeRef ? plotY : '0;
    assign oColour    = pipeRef ? iFbQ : '0;
    assign oBusy      = (state != IDLE);
    // pipeRef is still high in DRAIN only when the operation just retired was a refresh
    assign oFrameDone = (state == DRAIN) && pipeRef;
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench: three compositor instances (keyed, unkeyed, tiny-screen refresh)
// with behavioural sprite ROM and framebuffer RAM models.
module tb_vga_sprite_compositor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int x; int y; int c;} plot_t;
    wr_t   aExp[$];
    plot_t bExp[$];

    logic       rst, bRst;
    logic [4:0] req, bReq;
    logic [9:0] sel, bSel;
    logic [39:0] xs, bXs;
    logic [34:0] ys, bYs;

    logic [1:0]  aSprSel, cSprSel, bSprSel;
    logic [9:0]  aSprAddr, cSprAddr;
    logic [8:0]  bSprAddr;
    logic [2:0]  aSprColour, cSprColour, bSprColour;
    logic [14:0] aFbAddr, cFbAddr;
    logic [3:0]  bFbAddr;
    logic        aWren, cWren, bWren;
    logic [2:0]  aFbData, cFbData, bFbData;
    logic [2:0]  aFbQ, cFbQ, bFbQ;
    logic [7:0]  aX, cX, bX;
    logic [6:0]  aY, cY, bY;
    logic [2:0]  aColour, cColour, bColour;
    logic        aPlot, cPlot, bPlot, aBusy, cBusy, bBusy;
    logic        aDone, cDone, bDone, aMiss, cMiss, bMiss;

    vga_sprite_compositor #(.KEY_EN(1)) dutA (
        .clk(clk), .iResetn(rst), .iSlotReq(req), .iSlotSel(sel), .iSlotX(xs), .iSlotY(ys),
        .oSprSel(aSprSel), .oSprAddr(aSprAddr), .iSprColour(aSprColour),
        .oFbAddr(aFbAddr), .oFbWren(aWren), .oFbData(aFbData), .iFbQ(aFbQ),
        .oX(aX), .oY(aY), .oColour(aColour), .oPlot(aPlot), .oBusy(aBusy),
        .oFrameDone(aDone), .oFrameMiss(aMiss));

    vga_sprite_compositor #(.KEY_EN(0)) dutC (
        .clk(clk), .iResetn(rst), .iSlotReq(req), .iSlotSel(sel), .iSlotX(xs), .iSlotY(ys),
        .oSprSel(cSprSel), .oSprAddr(cSprAddr), .iSprColour(cSprColour),
        .oFbAddr(cFbAddr), .oFbWren(cWren), .oFbData(cFbData), .iFbQ(cFbQ),
        .oX(cX), .oY(cY), .oColour(cColour), .oPlot(cPlot), .oBusy(cBusy),
        .oFrameDone(cDone), .oFrameMiss(cMiss));

    vga_sprite_compositor #(.SCREEN_W(4), .SCREEN_H(3), .SPRITE_W(20), .SPRITE_H(20),
                            .REFRESH_DIV(64)) dutB (
        .clk(clk), .iResetn(bRst), .iSlotReq(bReq), .iSlotSel(bSel), .iSlotX(bXs), .iSlotY(bYs),
        .oSprSel(bSprSel), .oSprAddr(bSprAddr), .iSprColour(bSprColour),
        .oFbAddr(bFbAddr), .oFbWren(bWren), .oFbData(bFbData), .iFbQ(bFbQ),
        .oX(bX), .oY(bY), .oColour(bColour), .oPlot(bPlot), .oBusy(bBusy),
        .oFrameDone(bDone), .oFrameMiss(bMiss));

    function automatic logic [2:0] romVal(input int s, input int a);
        case (s)
            0:       return 3'((a % 7) + 1);
            1:       return 3'(((a * 3) % 7) + 1);
            2:       return ((a % 30) < 10) ? 3'd0 : 3'((a % 7) + 1);
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [2:0] ramVal(input int a);
        return 3'((a * 5 + 3) % 8);
    endfunction

    assign aFbQ = 3'd0;
    assign cFbQ = 3'd0;
    assign bSprColour = 3'd0;
    always @(posedge clk) begin
        aSprColour <= romVal(int'(aSprSel), int'(aSprAddr));
        cSprColour <= romVal(int'(cSprSel), int'(cSprAddr));
        bFbQ       <= ramVal(int'(bFbAddr));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-test write statistics for instance A (and the unkeyed twin C)
    int aWr = 0, testWr = 0, cTest = 0;
    int firstAddr, lastAddr, minAddr, maxAddr, minX;
    int bPlots = 0, bDoneCnt = 0, bMissCnt = 0;

    task automatic clrStats();
        testWr = 0; cTest = 0; firstAddr = -1; lastAddr = -1;
        minAddr = 1 << 30; maxAddr = -1; minX = 1 << 30;
    endtask

    always @(negedge clk) begin
        if (aWren) begin
            wr_t e;
            aWr++;
            if (testWr == 0) firstAddr = int'(aFbAddr);
            testWr++;
            lastAddr = int'(aFbAddr);
            if (int'(aFbAddr) < minAddr) minAddr = int'(aFbAddr);
            if (int'(aFbAddr) > maxAddr) maxAddr = int'(aFbAddr);
            if (int'(aFbAddr) % 160 < minX) minX = int'(aFbAddr) % 160;
            if (aExp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fbWrite unexpected: addr %0d data %0d, expected no write", aFbAddr, aFbData);
            end else begin
                e = aExp.pop_front();
                chk("fbWrite addr", int'(aFbAddr), e.addr);
                chk("fbWrite data", int'(aFbData), e.data);
            end
        end
        if (cWren) cTest++;
    end

    always @(negedge clk) begin
        if (bPlot) begin
            plot_t p;
            bPlots++;
            if (bExp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL plot unexpected: x %0d y %0d, expected no plot", bX, bY);
            end else begin
                p = bExp.pop_front();
                chk("plot x", int'(bX), p.x);
                chk("plot y", int'(bY), p.y);
                chk("plot colour", int'(bColour), p.c);
            end
        end
        if (bDone) bDoneCnt++;
        if (bMiss) bMissCnt++;
    end

    task automatic setSlot(input int s, input int sl, input int x, input int y, input bit push);
        sel[s*2 +: 2] = 2'(sl);
        xs[s*8 +: 8]  = 8'(x);
        ys[s*7 +: 7]  = 7'(y);
        if (push) begin
            for (int r = 0; r < 20; r++) begin
                for (int c = 0; c < 30; c++) begin
                    wr_t e;
                    logic [2:0] col;
                    col = romVal(sl, r * 30 + c);
                    if (col != 3'd0 && x + c < 160 && y + r < 120) begin
                        e.addr = (y + r) * 160 + x + c;
                        e.data = int'(col);
                        aExp.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic pulse(input logic [4:0] m);
        @(posedge clk); #1;
        req = m;
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic pushFrame();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) begin
                plot_t p;
                p.x = x; p.y = y; p.c = int'(ramVal(y * 4 + x));
                bExp.push_back(p);
            end
    endtask

    // Caller is at a negedge; gap counts low samples before busy, run counts busy samples
    task automatic busyRun(input bit useB, output int gap, output int run);
        gap = 0;
        run = 0;
        while (!(useB ? bBusy : aBusy) && gap < 300) begin gap++; @(negedge clk); end
        while ((useB ? bBusy : aBusy) && run < 2000) begin run++; @(negedge clk); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int g, r, g2, r2, g3, r3, base, n, mark, cnt, p0, m0;
        rst = 1'b1; bRst = 1'b1;
        req = '0; sel = '0; xs = '0; ys = '0;
        bReq = '0; bSel = '0; bXs = '0; bYs = '0;
        clrStats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset oFbWren", int'(aWren), 0);
        chk("reset oPlot", int'(aPlot), 0);
        chk("reset oBusy", int'(aBusy), 0);
        chk("reset oFbAddr", int'(aFbAddr), 0);
        chk("reset oSprAddr", int'(aSprAddr), 0);
        chk("reset oFbData", int'(aFbData), 0);
        chk("reset oFrameDone", int'(aDone), 0);
        chk("reset oFrameMiss", int'(aMiss), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Plain blit, slot 2 sel 1 at (97,31)
        clrStats();
        setSlot(2, 1, 97, 31, 1);
        pulse(5'b00100);
        @(negedge clk);
        busyRun(0, g, r);
        chk("blit busy cycles", r, 601);
        chk("blit write count", testWr, 600);
        chk("blit first addr", firstAddr, 5057);
        chk("blit last addr", lastAddr, 8126);

        // Transparent left 10 columns
        clrStats();
        setSlot(0, 2, 97, 31, 1);
        pulse(5'b00001);
        @(negedge clk);
        busyRun(0, g, r);
        chk("key busy cycles", r, 601);
        chk("key write count", testWr, 400);
        chk("key min x", minX, 107);
        chk("nokey write count", cTest, 600);

        // Clipping at bottom-right corner
        clrStats();
        setSlot(1, 0, 150, 110, 1);
        pulse(5'b00010);
        @(negedge clk);
        busyRun(0, g, r);
        chk("clip write count", testWr, 100);
        chk("clip min addr", minAddr, 17750);
        chk("clip max addr", maxAddr, 19199);

        // Arbitration: slots 0 and 3 together, then slot 0 re-request during slot 3
        clrStats();
        setSlot(0, 0, 0, 0, 1);
        setSlot(3, 3, 40, 40, 1);
        pulse(5'b01001);
        @(negedge clk);
        busyRun(0, g, r);
        chk("arb first busy", r, 601);
        chk("arb slot0 first addr", firstAddr, 0);
        chk("arb slot0 last addr", lastAddr, 3069);
        fork
            busyRun(0, g2, r2);
            begin
                repeat (100) @(posedge clk);
                #1;
                setSlot(0, 1, 5, 60, 1);
                req = 5'b00001;
                @(posedge clk); #1;
                req = '0;
            end
        join
        chk("arb slot3 idle gap", g2, 1);
        chk("arb slot3 busy", r2, 601);
        busyRun(0, g3, r3);
        chk("arb slot0 again gap", g3, 1);
        chk("arb slot0 again busy", r3, 601);

        // Reset mid-blit after 37 pixels, with slot 1 left pending
        clrStats();
        base = aWr;
        setSlot(4, 0, 10, 10, 1);
        setSlot(1, 0, 0, 0, 0);
        pulse(5'b10000);
        pulse(5'b00010);
        n = 0;
        while (aWr < base + 37 && n < 1000) begin @(posedge clk); n++; end
        chk("writes before reset", aWr - base, 37);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        aExp.delete();
        mark = aWr;
        @(negedge clk);
        chk("reset oFbWren after edge", int'(aWren), 0);
        chk("reset oBusy after edge", int'(aBusy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (60) begin @(negedge clk); if (aBusy) cnt++; end
        chk("pend cleared busy cycles", cnt, 0);
        chk("no writes after reset", aWr - mark, 0);

        clrStats();
        setSlot(4, 0, 10, 10, 1);
        pulse(5'b10000);
        @(negedge clk);
        busyRun(0, g, r);
        chk("post-reset busy", r, 601);
        chk("post-reset write count", testWr, 600);
        chk("post-reset first addr", firstAddr, 1610);

        // Refresh on 4x3 screen
        pushFrame();
        @(posedge clk); #1;
        bRst = 1'b0;
        n = 0;
        while (bDoneCnt < 1 && n < 300) begin @(negedge clk); n++; end
        chk("refresh frameDone count", bDoneCnt, 1);
        chk("refresh plot count", bPlots, 12);

        // Ticks during a 20x20 blit: deferred refresh, then misses
        pushFrame();
        p0 = bPlots;
        m0 = bMissCnt;
        @(posedge clk); #1;
        bReq = 5'b00001;
        @(posedge clk); #1;
        bReq = '0;
        @(negedge clk);
        busyRun(1, g, r);
        chk("B blit busy", r, 401);
        chk("no plot during blit", bPlots - p0, 0);
        chk("frameMiss seen", int'(bMissCnt > m0), 1);
        n = 0;
        while (bDoneCnt < 2 && n < 300) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bRst = 1'b1;
        chk("deferred frameDone count", bDoneCnt, 2);
        chk("deferred plot count", bPlots, 24);

        repeat (4) @(negedge clk);
        chk("A scoreboard empty", aExp.size(), 0);
        chk("B scoreboard empty", bExp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
